// File: rtl/apb_intercon_shared.sv
// apb_intercon_shared
//   Shared-bus APB interconnect: MASTER_PORTS upstream APB masters compete for
//   one downstream APB bus that fans out to SLAVE_PORTS slaves. A round-robin
//   arbiter picks one requester at a time. Its transfer is replayed downstream
//   to the slave selected by PADDR[ADDR_MSB:ADDR_LSB], and the result is
//   returned to that master.
//
// Ports
//   clk, reset   : clock (rising edge); asynchronous active-low reset
//   S_PADDR      : per-master address, master i at [i*BUS_WIDTH +: BUS_WIDTH]
//   S_PWRITE     : per-master direction (1 = write)
//   S_PSELx      : per-master select, which acts as the request
//   S_PENABLE    : per-master enable
//   S_PWDATA     : per-master write data
//   S_PRDATA     : per-master read data (registered, held between reads)
//   S_PREADY     : per-master completion
//   M_PADDR/M_PWRITE/M_PWDATA : shared downstream address, direction and data
//   M_PSELx      : one-hot downstream slave select
//   M_PENABLE    : shared downstream enable
//   M_PRDATA     : per-slave read data
//   M_PREADY     : per-slave ready
module apb_intercon_shared #(
  parameter int BUS_WIDTH    = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int MASTER_PORTS = 4,
  parameter int SLAVE_PORTS  = 2,
  parameter int ADDR_MSB     = 12,
  parameter int ADDR_LSB     = 12
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
  input  logic [MASTER_PORTS-1:0]            S_PWRITE,
  input  logic [MASTER_PORTS-1:0]            S_PSELx,
  input  logic [MASTER_PORTS-1:0]            S_PENABLE,
  input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]            S_PREADY,
  output logic [BUS_WIDTH-1:0]               M_PADDR,
  output logic                               M_PWRITE,
  output logic [SLAVE_PORTS-1:0]             M_PSELx,
  output logic                               M_PENABLE,
  output logic [DATA_WIDTH-1:0]              M_PWDATA,
  input  logic [SLAVE_PORTS*DATA_WIDTH-1:0]  M_PRDATA,
  input  logic [SLAVE_PORTS-1:0]             M_PREADY
);

  localparam int MW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
  localparam int IW = ADDR_MSB - ADDR_LSB + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t                state_reg;
  logic [MW-1:0]         grant_reg;
  logic [MW-1:0]         rr_ptr_reg;
  logic [IW-1:0]         idx_reg;
  logic [BUS_WIDTH-1:0]  addr_reg;
  logic                  write_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [SLAVE_PORTS-1:0] psel_reg;
  logic                  penable_reg;
  logic [DATA_WIDTH-1:0] prdata_reg [MASTER_PORTS];

  logic [BUS_WIDTH-1:0]  s_addr_arr  [MASTER_PORTS];
  logic [DATA_WIDTH-1:0] s_wdata_arr [MASTER_PORTS];
  logic [DATA_WIDTH-1:0] m_rdata_arr [SLAVE_PORTS];

  logic                  req_any;
  logic [MW-1:0]         grant_next;
  logic [IW-1:0]         dec_idx;
  logic [SLAVE_PORTS-1:0] dec_onehot;
  logic                  dec_ok;
  logic                  sel_ready;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  done_fire;
  logic [MW-1:0]         rr_next;

  genvar gi;
  generate
    for (gi = 0; gi < MASTER_PORTS; gi++) begin : g_master
      assign s_addr_arr[gi]  = S_PADDR[gi*BUS_WIDTH +: BUS_WIDTH];
      assign s_wdata_arr[gi] = S_PWDATA[gi*DATA_WIDTH +: DATA_WIDTH];
      assign S_PRDATA[gi*DATA_WIDTH +: DATA_WIDTH] = prdata_reg[gi];
      // Completion is presented combinationally in DONE so the master sees
      // PREADY in the same cycle its PSEL&PENABLE qualify the handshake.
      assign S_PREADY[gi] = done_fire && (grant_reg == MW'(gi));
    end
    for (gi = 0; gi < SLAVE_PORTS; gi++) begin : g_slave
      assign m_rdata_arr[gi] = M_PRDATA[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Round-robin pick: the first requester at or after rr_ptr_reg, wrapping.
  always_comb begin
    req_any    = 1'b0;
    grant_next = '0;
    for (int k = 0; k < MASTER_PORTS; k++) begin
      int            cand;
      logic [MW-1:0] cand_idx;
      cand = int'(rr_ptr_reg) + k;
      if (cand >= MASTER_PORTS) cand = cand - MASTER_PORTS;
      cand_idx = MW'(cand);
      if (!req_any && S_PSELx[cand_idx]) begin
        req_any    = 1'b1;
        grant_next = cand_idx;
      end
    end
  end

  assign dec_idx = s_addr_arr[grant_next][ADDR_MSB:ADDR_LSB];

  // The decoded slave select is one-hot. An out-of-range index selects
  // nothing, and that transfer bypasses the downstream bus.
  always_comb begin
    dec_onehot = '0;
    sel_ready  = 1'b0;
    sel_rdata  = '0;
    for (int s = 0; s < SLAVE_PORTS; s++) begin
      if (int'(dec_idx) == s) dec_onehot[s] = 1'b1;
      if (int'(idx_reg) == s) begin
        sel_ready = M_PREADY[s];
        sel_rdata = m_rdata_arr[s];
      end
    end
  end

  assign dec_ok    = |dec_onehot;
  assign done_fire = (state_reg == DONE) && S_PSELx[grant_reg] && S_PENABLE[grant_reg];
  assign rr_next   = (int'(grant_reg) == MASTER_PORTS - 1) ? '0 : grant_reg + 1'b1;

  assign M_PADDR   = addr_reg;
  assign M_PWRITE  = write_reg;
  assign M_PWDATA  = wdata_reg;
  assign M_PSELx   = psel_reg;
  assign M_PENABLE = penable_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg   <= IDLE;
      grant_reg   <= '0;
      rr_ptr_reg  <= '0;
      idx_reg     <= '0;
      addr_reg    <= '0;
      write_reg   <= 1'b0;
      wdata_reg   <= '0;
      psel_reg    <= '0;
      penable_reg <= 1'b0;
      for (int i = 0; i < MASTER_PORTS; i++) prdata_reg[i] <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_any) begin
            grant_reg <= grant_next;
            addr_reg  <= s_addr_arr[grant_next];
            write_reg <= S_PWRITE[grant_next];
            wdata_reg <= s_wdata_arr[grant_next];
            idx_reg   <= dec_idx;
            if (dec_ok) begin
              psel_reg  <= dec_onehot;
              state_reg <= SETUP;
            end else begin
              // No slave lives here: a read returns zero and a write is dropped.
              if (!S_PWRITE[grant_next]) prdata_reg[grant_next] <= '0;
              state_reg <= DONE;
            end
          end
        end
        SETUP: begin
          penable_reg <= 1'b1;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          if (sel_ready) begin
            psel_reg    <= '0;
            penable_reg <= 1'b0;
            if (!write_reg) prdata_reg[grant_reg] <= sel_rdata;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          if (done_fire) begin
            rr_ptr_reg <= rr_next;
            state_reg  <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_intercon_shared.sv
module tb_apb_intercon_shared;
  localparam int BW = 16;
  localparam int DW = 16;
  localparam int NM = 4;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NM*BW-1:0] S_PADDR;
  logic [NM-1:0]    S_PWRITE, S_PSELx, S_PENABLE, S_PREADY;
  logic [NM*DW-1:0] S_PWDATA, S_PRDATA;
  logic [BW-1:0]    M_PADDR;
  logic             M_PWRITE, M_PENABLE;
  logic [NS-1:0]    M_PSELx, M_PREADY;
  logic [DW-1:0]    M_PWDATA;
  logic [NS*DW-1:0] M_PRDATA;

  apb_intercon_shared dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE),
    .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
    .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY)
  );

  // Per-master drive state
  logic [BW-1:0] m_addr  [NM];
  logic [DW-1:0] m_wdata [NM];
  logic          m_wr    [NM];
  logic          m_sel   [NM];
  logic          m_en    [NM];

  always_comb begin
    S_PADDR = '0; S_PWDATA = '0; S_PWRITE = '0; S_PSELx = '0; S_PENABLE = '0;
    for (int i = 0; i < NM; i++) begin
      S_PADDR[i*BW +: BW]  = m_addr[i];
      S_PWDATA[i*DW +: DW] = m_wdata[i];
      S_PWRITE[i]  = m_wr[i];
      S_PSELx[i]   = m_sel[i];
      S_PENABLE[i] = m_en[i];
    end
  end

  // Slave environment: two memories with a programmable wait count
  logic [DW-1:0] smem [NS][256];
  int wait_cfg = 0;
  int wait_left = 0;

  always @(posedge clk) begin
    if (M_PSELx != '0 && !M_PENABLE)
      wait_left <= (wait_cfg >= 0) ? wait_cfg : int'($urandom_range(0, 2));
    else if (M_PENABLE && wait_left > 0)
      wait_left <= wait_left - 1;
    for (int s = 0; s < NS; s++)
      if (M_PSELx[s] && M_PENABLE && M_PREADY[s] && M_PWRITE)
        smem[s][M_PADDR[7:0]] <= M_PWDATA;
  end

  always_comb begin
    M_PREADY = '0; M_PRDATA = '0;
    for (int s = 0; s < NS; s++) begin
      M_PREADY[s] = M_PSELx[s] && M_PENABLE && (wait_left == 0);
      M_PRDATA[s*DW +: DW] = smem[s][M_PADDR[7:0]];
    end
  end

  // Reference model: flat address space, unwritten locations read addr^A5A5
  typedef struct { int m; bit rd; logic [DW-1:0] data; } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] ref_mem [logic [BW-1:0]];
  logic [DW-1:0] last_rd [NM];
  int            rr_model = 0;
  int            exp_grant = -1;
  int            comp_order[$];
  logic [NS-1:0] setup_psel;
  logic [BW-1:0] setup_addr;
  logic [DW-1:0] setup_wdata;
  logic          setup_write;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [DW-1:0] ref_read(input logic [BW-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return a ^ 16'hA5A5;
  endfunction

  function automatic int rr_pick(input logic [NM-1:0] req, input int rr);
    for (int k = 0; k < NM; k++) begin
      int j;
      j = (rr + k) % NM;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: downstream SETUP checks and upstream completion scoreboard
  initial begin
    logic [NM-1:0] req_prev;
    req_prev = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (M_PSELx != '0 && !M_PENABLE) begin
          check("m_psel_decode", M_PSELx, M_PADDR[12] ? 2'b10 : 2'b01);
          exp_grant   = rr_pick(req_prev, rr_model);
          setup_psel  = M_PSELx;
          setup_addr  = M_PADDR;
          setup_wdata = M_PWDATA;
          setup_write = M_PWRITE;
        end
        if (S_PREADY != '0) begin
          int m, idx;
          m = -1; idx = -1;
          for (int i = 0; i < NM; i++) if (S_PREADY[i] && m < 0) m = i;
          check("s_pready_onehot", $countones(S_PREADY), 1);
          check("rr_grant", m, exp_grant);
          rr_model = (m + 1) % NM;
          comp_order.push_back(m);
          foreach (exp_q[i]) if (idx < 0 && exp_q[i].m == m) idx = i;
          if (idx < 0) begin
            check("sb_unexpected_done", 1, 0);
          end else begin
            $display("done m%0d %s prdata=%h exp=%h", m, exp_q[idx].rd ? "RD" : "WR",
                     S_PRDATA[m*DW +: DW], exp_q[idx].data);
            check(exp_q[idx].rd ? "sb_read_data" : "sb_hold_data",
                  S_PRDATA[m*DW +: DW], exp_q[idx].data);
            exp_q.delete(idx);
          end
        end
      end
      req_prev = S_PSELx;
    end
  end

  // One APB transfer from master m. Entered and left just after a rising edge.
  // lat counts edges from PSEL assertion to the cycle S_PREADY is seen.
  task automatic apb_xfer(input int m, input logic wr, input logic [BW-1:0] a,
                          input logic [DW-1:0] d, output int lat);
    exp_t e;
    if (wr) begin
      ref_mem[a] = d;
      e = '{m: m, rd: 1'b0, data: last_rd[m]};
    end else begin
      e = '{m: m, rd: 1'b1, data: ref_read(a)};
      last_rd[m] = e.data;
    end
    exp_q.push_back(e);
    m_addr[m] = a; m_wr[m] = wr; m_wdata[m] = d; m_sel[m] = 1'b1; m_en[m] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      m_en[m] = 1'b1;
    end while (!S_PREADY[m] && lat < 300);
    if (lat >= 300) check("xfer_timeout", 0, 1);
    @(posedge clk); #1;
    m_sel[m] = 1'b0; m_en[m] = 1'b0;
  endtask

  task automatic rand_driver(input int m);
    for (int n = 0; n < 25; n++) begin
      int gap, l;
      logic [5:0] r6;
      logic       sbit, wr;
      logic [BW-1:0] a;
      gap  = int'($urandom_range(0, 2));
      r6   = 6'($urandom_range(0, 63));
      sbit = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      a    = {3'b000, sbit, 4'b0000, r6, 2'(m)};
      for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
      apb_xfer(m, wr, a, 16'($urandom), l);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, l0, l1, l2, l3;
    reset = 1'b0;
    for (int i = 0; i < NM; i++) begin
      m_addr[i] = '0; m_wdata[i] = '0; m_wr[i] = 1'b0; m_sel[i] = 1'b0; m_en[i] = 1'b0;
      last_rd[i] = '0;
    end
    for (int s = 0; s < NS; s++)
      for (int a = 0; a < 256; a++)
        smem[s][a] = {3'b000, 1'(s), 4'b0000, 8'(a)} ^ 16'hA5A5;

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_psel", M_PSELx, 0);
    check("rst_m_penable", M_PENABLE, 0);
    check("rst_m_paddr", M_PADDR, 0);
    check("rst_s_pready", S_PREADY, 0);
    check("rst_s_prdata", S_PRDATA, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // All four masters request together: grants 0,1,2,3
    comp_order.delete();
    fork
      apb_xfer(0, 1'b1, 16'h0040, 16'hA000, l0);
      apb_xfer(1, 1'b1, 16'h1041, 16'hA001, l1);
      apb_xfer(2, 1'b1, 16'h0042, 16'hA002, l2);
      apb_xfer(3, 1'b1, 16'h1043, 16'hA003, l3);
    join
    check("t4_order_len", comp_order.size(), 4);
    for (int i = 0; i < 4 && i < comp_order.size(); i++) check("t4_order", comp_order[i], i);
    // Pointer has wrapped to 0: M1 beats M3
    comp_order.delete();
    fork
      apb_xfer(1, 1'b0, 16'h1041, 16'h0, l1);
      apb_xfer(3, 1'b0, 16'h0043, 16'h0, l3);
    join
    check("t4_m1_first", comp_order.size() > 0 ? comp_order[0] : -1, 1);

    // M1 write, single requester, zero-wait slave
    apb_xfer(1, 1'b1, 16'h0011, 16'h1111, lat);
    check("t1_latency", lat, 3);
    check("t1_m_psel", setup_psel, 2'b01);
    check("t1_m_paddr", setup_addr, 16'h0011);
    check("t1_m_pwdata", setup_wdata, 16'h1111);
    check("t1_m_pwrite", setup_write, 1);

    // M3 writes peripheral slave, M0 reads it back
    apb_xfer(3, 1'b1, 16'h1003, 16'h3333, lat);
    check("t2_w_psel", setup_psel, 2'b10);
    apb_xfer(0, 1'b0, 16'h1003, 16'h0, lat);
    check("t2_r_psel", setup_psel, 2'b10);
    check("t2_prdata0", S_PRDATA[15:0], 16'h3333);
    apb_xfer(0, 1'b1, 16'h0050, 16'h5555, lat);
    check("t2_prdata0_held", S_PRDATA[15:0], 16'h3333);

    // M2 writes two locations and reads both back
    apb_xfer(2, 1'b1, 16'h0022, 16'h2222, lat);
    apb_xfer(2, 1'b1, 16'h0027, 16'h2277, lat);
    apb_xfer(2, 1'b0, 16'h0022, 16'h0, lat);
    check("t3_rd_a", S_PRDATA[47:32], 16'h2222);
    apb_xfer(2, 1'b0, 16'h0027, 16'h0, lat);
    check("t3_rd_b", S_PRDATA[47:32], 16'h2277);

    // Slave inserts three wait cycles
    wait_cfg = 3;
    apb_xfer(2, 1'b0, 16'h0022, 16'h0, lat);
    check("t5_latency", lat, 6);
    wait_cfg = 0;

    // Randomized concurrent traffic with random wait states
    wait_cfg = -1;
    fork
      rand_driver(0);
      rand_driver(1);
      rand_driver(2);
      rand_driver(3);
    join
    wait_cfg = 0;
    check("sb_drained", exp_q.size(), 0);

    // Reset asserted in the middle of ACCESS
    wait_cfg = 5;
    m_addr[0] = 16'h1003; m_wr[0] = 1'b0; m_wdata[0] = '0; m_sel[0] = 1'b1; m_en[0] = 1'b0;
    @(posedge clk); #1;
    m_en[0] = 1'b1;
    for (int k = 0; k < 20 && !M_PENABLE; k++) begin @(posedge clk); #1; end
    check("t6_in_access", M_PENABLE, 1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_m_psel", M_PSELx, 0);
    check("t6_m_penable", M_PENABLE, 0);
    check("t6_m_paddr", M_PADDR, 0);
    check("t6_m_pwdata", M_PWDATA, 0);
    check("t6_m_pwrite", M_PWRITE, 0);
    check("t6_s_pready", S_PREADY, 0);
    check("t6_s_prdata", S_PRDATA, 0);
    m_sel[0] = 1'b0; m_en[0] = 1'b0;
    for (int i = 0; i < NM; i++) last_rd[i] = '0;
    rr_model = 0; exp_grant = -1;
    exp_q.delete();
    wait_cfg = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    apb_xfer(0, 1'b0, 16'h1003, 16'h0, lat);
    check("t6_restart_latency", lat, 3);
    check("t6_restart_data", S_PRDATA[15:0], ref_read(16'h1003));
    check("sb_final_drained", exp_q.size(), 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
